// File: rtl/flag_ctrl_unit.sv
// Status-flag sequencer for the MCU: carry, zero and interrupt enable, plus
// interrupt entry/exit with a small {C,Z} shadow stack for nested interrupts.
//
// state | meaning
// RUN   | accepting flag commands, watching for an enabled interrupt
// SAVE  | pushing {C,Z} to the shadow stack, masking interrupts
// ACK   | pulsing int_ack so the core fetches the vector
module flag_ctrl_unit #(
    parameter int SHADOW_DEPTH = 2,
    parameter int PTR_W        = $clog2(SHADOW_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       flg_op,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             c_in,
    input  logic             z_in,
    input  logic             intr,
    output logic             c_flag,
    output logic             z_flag,
    output logic             i_flag,
    output logic             int_ack,
    output logic [PTR_W-1:0] shadow_cnt,
    output logic             stk_err
);

    localparam int IDX_W = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;
    localparam logic [PTR_W-1:0] FULL = PTR_W'(SHADOW_DEPTH);

    localparam logic [2:0] OP_LD_CZ = 3'b001;
    localparam logic [2:0] OP_LD_C  = 3'b010;
    localparam logic [2:0] OP_SET_C = 3'b011;
    localparam logic [2:0] OP_CLR_C = 3'b100;
    localparam logic [2:0] OP_SEI   = 3'b101;
    localparam logic [2:0] OP_CLI   = 3'b110;
    localparam logic [2:0] OP_RETI  = 3'b111;

    typedef enum logic [1:0] {RUN, SAVE, ACK} state_t;

    state_t             state, state_nxt;
    logic               c_nxt, z_nxt, i_nxt, err_nxt, push;
    logic [PTR_W-1:0]   cnt_nxt;
    logic [1:0]         shadow [SHADOW_DEPTH];

    assign cmd_ready = (state == RUN);
    assign int_ack   = (state == ACK);

    always_comb begin
        state_nxt = state;
        c_nxt     = c_flag;
        z_nxt     = z_flag;
        i_nxt     = i_flag;
        err_nxt   = stk_err;
        cnt_nxt   = shadow_cnt;
        push      = 1'b0;
        case (state)
            RUN: begin
                if (cmd_valid) begin
                    case (flg_op)
                        OP_LD_CZ: begin
                            c_nxt = c_in;
                            z_nxt = z_in;
                        end
                        OP_LD_C:  c_nxt = c_in;
                        OP_SET_C: c_nxt = 1'b1;
                        OP_CLR_C: c_nxt = 1'b0;
                        OP_SEI:   i_nxt = 1'b1;
                        OP_CLI:   i_nxt = 1'b0;
                        OP_RETI: begin
                            i_nxt = 1'b1;
                            if (shadow_cnt != '0) begin
                                {c_nxt, z_nxt} = shadow[IDX_W'(shadow_cnt - PTR_W'(1))];
                                cnt_nxt        = shadow_cnt - PTR_W'(1);
                            end else begin
                                err_nxt = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                // take decision uses the registered I, so a same-edge CLI cannot cancel it
                if (intr && i_flag) state_nxt = SAVE;
            end
            SAVE: begin
                i_nxt     = 1'b0;
                state_nxt = ACK;
                if (shadow_cnt == FULL) begin
                    err_nxt = 1'b1;
                end else begin
                    push    = 1'b1;
                    cnt_nxt = shadow_cnt + PTR_W'(1);
                end
            end
            ACK:     state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            c_flag     <= 1'b0;
            z_flag     <= 1'b0;
            i_flag     <= 1'b0;
            stk_err    <= 1'b0;
            shadow_cnt <= '0;
        end else begin
            state      <= state_nxt;
            c_flag     <= c_nxt;
            z_flag     <= z_nxt;
            i_flag     <= i_nxt;
            stk_err    <= err_nxt;
            shadow_cnt <= cnt_nxt;
        end
    end

    // shadow contents are deliberately not reset; only the count is
    always_ff @(posedge clk) begin
        if (push) shadow[IDX_W'(shadow_cnt)] <= {c_flag, z_flag};
    end

endmodule
